// File: rtl/pixel_stream_ctrl_if.sv
// Classifier-side link: pixel stream out of the controller, result strobe back into it.
interface pixel_stream_ctrl_if #(
    parameter int PIX_W = 1
) ();
    logic [PIX_W-1:0] px_data;
    logic             px_valid;
    logic             px_ready;
    logic             res_valid;
    logic [3:0]       res_pred;
    logic [7:0]       res_conf;

    modport master (
        output px_data, px_valid,
        input  px_ready, res_valid, res_pred, res_conf
    );

    modport slave (
        input  px_data, px_valid,
        output px_ready, res_valid, res_pred, res_conf
    );
endinterface

// File: rtl/pixel_stream_ctrl.sv
// Streams buffered images pixel by pixel to a classifier and collects one
// prediction per image into a result table, with a per-image result watchdog.
module pixel_stream_ctrl #(
    parameter int PIX_W   = 1,
    parameter int N_PIX   = 784,
    parameter int N_IMG   = 4,
    parameter int TIMEOUT = 2000,
    localparam int DEPTH     = N_IMG * N_PIX,
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(N_IMG + 1),
    localparam int IDX_W     = (N_IMG > 1) ? $clog2(N_IMG) : 1,
    localparam int PIX_IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1,
    localparam int WDOG_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [PIX_W-1:0]     wr_data,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_img,
    pixel_stream_ctrl_if.master  cls,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     img_cnt,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [3:0]           rd_pred,
    output logic [7:0]           rd_conf
);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, FINISH} state_e;

    localparam logic [PIX_IDX_W-1:0] PIX_LAST  = PIX_IDX_W'(N_PIX - 1);
    localparam logic [WDOG_W-1:0]    WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       img_q, img_d;
    logic [PIX_IDX_W-1:0]   pix_q, pix_d;
    logic [WDOG_W-1:0]      wdog_q, wdog_d;
    logic [CNT_W-1:0]       num_img_q, num_img_d;
    logic [CNT_W-1:0]       img_cnt_q, img_cnt_d;
    logic                   done_q, done_d;
    logic                   terr_q, terr_d;
    logic [3:0]             pred_tbl_q [N_IMG];
    logic [3:0]             pred_tbl_d [N_IMG];
    logic [7:0]             conf_tbl_q [N_IMG];
    logic [7:0]             conf_tbl_d [N_IMG];

    logic [PIX_W-1:0]       pix_mem [DEPTH];
    logic [PIX_W-1:0]       mem_rd_q;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   px_valid;

    // NOTE: non-blocking assignments in every clocked process so all flops
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            img_q     <= '0;
            pix_q     <= '0;
            wdog_q    <= '0;
            num_img_q <= '0;
            img_cnt_q <= '0;
            done_q    <= 1'b0;
            terr_q    <= 1'b0;
            for (int i = 0; i < N_IMG; i++) begin
                pred_tbl_q[i] <= '0;
                conf_tbl_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            img_q      <= img_d;
            pix_q      <= pix_d;
            wdog_q     <= wdog_d;
            num_img_q  <= num_img_d;
            img_cnt_q  <= img_cnt_d;
            done_q     <= done_d;
            terr_q     <= terr_d;
            pred_tbl_q <= pred_tbl_d;
            conf_tbl_q <= conf_tbl_d;
        end
    end

    // NOTE: the pixel buffer has no reset so it maps onto block RAM; its
    // contents are only meaningful after software has written them.
    always_ff @(posedge clk) begin
        if (wr_en && !busy && (int'(wr_addr) < DEPTH))
            pix_mem[wr_addr] <= wr_data;
        mem_rd_q <= pix_mem[mem_addr];
    end

    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        img_d      = img_q;
        pix_d      = pix_q;
        wdog_d     = '0;
        num_img_d  = num_img_q;
        img_cnt_d  = img_cnt_q;
        done_d     = 1'b0;
        terr_d     = terr_q;
        pred_tbl_d = pred_tbl_q;
        conf_tbl_d = conf_tbl_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (int'(num_img) == 0 || int'(num_img) > N_IMG) begin
                        done_d = 1'b1;
                        terr_d = 1'b0;
                    end else begin
                        state_d   = STREAM;
                        num_img_d = num_img;
                        img_cnt_d = '0;
                        terr_d    = 1'b0;
                        img_d     = '0;
                        pix_d     = '0;
                    end
                end
            end
            STREAM: begin
                // px_valid is constant-high here, so px_ready alone is the handshake.
                if (cls.px_ready) begin
                    if (pix_q == PIX_LAST) begin
                        state_d = WAIT_RES;
                        pix_d   = '0;
                    end else begin
                        pix_d = pix_q + PIX_IDX_W'(1);
                    end
                end
            end
            WAIT_RES: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (cls.res_valid) begin
                    pred_tbl_d[img_q] = cls.res_pred;
                    conf_tbl_d[img_q] = cls.res_conf;
                    img_cnt_d         = img_cnt_q + CNT_W'(1);
                    wdog_d            = '0;
                    if (int'(img_q) + 1 == int'(num_img_q)) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = STREAM;
                        img_d   = img_q + IDX_W'(1);
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    terr_d  = 1'b1;
                    wdog_d  = '0;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Read address tracks the position that will be presented next cycle,
        // hiding the one-cycle RAM latency.
        mem_addr = ADDR_W'(int'(img_d) * N_PIX + int'(pix_d));
    end

    always_comb begin
        px_valid = (state_q == STREAM);
        busy     = (state_q == STREAM) || (state_q == WAIT_RES);
        rd_pred  = '0;
        rd_conf  = '0;
        if (int'(rd_idx) < N_IMG) begin
            rd_pred = pred_tbl_q[rd_idx];
            rd_conf = conf_tbl_q[rd_idx];
        end
    end

    assign cls.px_valid = px_valid;
    assign cls.px_data  = mem_rd_q;
    assign done         = done_q;
    assign timeout_err  = terr_q;
    assign img_cnt      = img_cnt_q;

endmodule

// File: tb/tb_pixel_stream_ctrl.sv
// Directed bench for pixel_stream_ctrl: single/multi-image runs, stalls,
// watchdog timeout, invalid starts and mid-stream reset.
module tb_pixel_stream_ctrl;

    localparam int PIX_W   = 1;
    localparam int N_PIX   = 784;
    localparam int N_IMG   = 4;
    localparam int TIMEOUT = 2000;
    localparam int ADDR_W  = $clog2(N_IMG * N_PIX);
    localparam int CNT_W   = $clog2(N_IMG + 1);
    localparam int IDX_W   = $clog2(N_IMG);

    typedef struct {
        int   num;
        logic exp_done;
        logic exp_busy;
        logic exp_terr;
    } start_vec_t;

    typedef struct {
        int   idx;
        int   exp_pred;
        int   exp_conf;
    } rd_vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               wr_en = 1'b0;
    logic [ADDR_W-1:0]  wr_addr = '0;
    logic [PIX_W-1:0]   wr_data = '0;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   num_img = '0;
    logic               busy, done, timeout_err;
    logic [CNT_W-1:0]   img_cnt;
    logic [IDX_W-1:0]   rd_idx = '0;
    logic [3:0]         rd_pred;
    logic [7:0]         rd_conf;

    int checks = 0;
    int errors = 0;

    pixel_stream_ctrl_if #(.PIX_W(PIX_W)) cls_if ();

    pixel_stream_ctrl #(
        .PIX_W(PIX_W), .N_PIX(N_PIX), .N_IMG(N_IMG), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .num_img(num_img),
        .cls(cls_if),
        .busy(busy), .done(done), .timeout_err(timeout_err), .img_cnt(img_cnt),
        .rd_idx(rd_idx), .rd_pred(rd_pred), .rd_conf(rd_conf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PIX_W-1:0] exp_pix(input int img, input int pix);
        int h;
        h = pix ^ (pix >> 3) ^ ((pix * (img + 1)) >> 2);
        return PIX_W'(h & 1);
    endfunction

    task automatic do_start(input int n);
        num_img = CNT_W'(n);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic give_result(input logic [3:0] p, input logic [7:0] c, input int gap);
        repeat (gap) tick();
        cls_if.res_valid = 1'b1;
        cls_if.res_pred  = p;
        cls_if.res_conf  = c;
        tick();
        cls_if.res_valid = 1'b0;
    endtask

    task automatic read_entry(input string name, input int idx, input int p, input int c);
        rd_idx = IDX_W'(idx);
        #1;
        check({name, " pred"}, 32'(rd_pred), p);
        check({name, " conf"}, 32'(rd_conf), c);
    endtask

    // Consumes up to n_hs handshakes of image img; optionally toggles ready,
    // drives spurious results, and issues start/writes that must be ignored.
    task automatic stream_img(input int img, input int n_hs, input bit toggle,
                              input bit junk, input bit glitch,
                              output int hs, output int bad, output int stall_bad);
        int          cyc;
        bit          prev_stall;
        logic [PIX_W-1:0] prev_d;
        hs = 0; bad = 0; stall_bad = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0;
        while (hs < n_hs && cyc < 4 * N_PIX) begin
            if (prev_stall && cls_if.px_data !== prev_d) stall_bad++;
            cls_if.px_ready  = toggle ? ~cyc[0] : 1'b1;
            cls_if.res_valid = junk;
            cls_if.res_pred  = 4'hf;
            cls_if.res_conf  = 8'hff;
            if (glitch && cyc == 50) begin
                start   = 1'b1;
                num_img = CNT_W'(2);
            end else begin
                start = 1'b0;
            end
            wr_en = glitch && cyc >= 50 && cyc < 60;
            if (wr_en) begin
                wr_addr = ADDR_W'(img * N_PIX + cyc + 100);
                wr_data = ~exp_pix(img, cyc + 100);
            end
            prev_stall = cls_if.px_valid && !cls_if.px_ready;
            prev_d     = cls_if.px_data;
            if (cls_if.px_valid && cls_if.px_ready) begin
                if (cls_if.px_data !== exp_pix(img, hs)) bad++;
                hs++;
            end
            tick();
            cyc++;
        end
        cls_if.res_valid = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        start_vec_t sv [3];
        rd_vec_t    rv [4];
        int hs, bad, sb, n;

        sv[0] = '{num: 0, exp_done: 1'b1, exp_busy: 1'b0, exp_terr: 1'b0};
        sv[1] = '{num: 5, exp_done: 1'b1, exp_busy: 1'b0, exp_terr: 1'b0};
        sv[2] = '{num: 7, exp_done: 1'b1, exp_busy: 1'b0, exp_terr: 1'b0};
        rv[0] = '{idx: 0, exp_pred: 3, exp_conf: 10};
        rv[1] = '{idx: 1, exp_pred: 5, exp_conf: 20};
        rv[2] = '{idx: 2, exp_pred: 9, exp_conf: 30};
        rv[3] = '{idx: 3, exp_pred: 0, exp_conf: 0};

        cls_if.px_ready  = 1'b0;
        cls_if.res_valid = 1'b0;
        cls_if.res_pred  = '0;
        cls_if.res_conf  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst px_valid", 32'(cls_if.px_valid), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst timeout_err", 32'(timeout_err), 0);
        check("rst img_cnt", 32'(img_cnt), 0);
        read_entry("rst tbl3", 3, 0, 0);
        rst_n = 1'b1;
        tick();

        for (int a = 0; a < N_IMG * N_PIX; a++) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(a);
            wr_data = exp_pix(a / N_PIX, a % N_PIX);
            tick();
        end
        wr_en = 1'b0;

        // Result strobe while idle must be dropped
        give_result(4'hf, 8'hff, 0);
        check("idle res img_cnt", 32'(img_cnt), 0);
        check("idle res done", 32'(done), 0);
        read_entry("idle res tbl0", 0, 0, 0);

        // Single image, ready always high, start/writes while busy
        do_start(1);
        check("A busy", 32'(busy), 1);
        stream_img(0, N_PIX, 1'b0, 1'b0, 1'b1, hs, bad, sb);
        check("A handshakes", hs, N_PIX);
        check("A pixel errors", bad, 0);
        check("A px_valid after last", 32'(cls_if.px_valid), 0);
        check("A busy in wait", 32'(busy), 1);
        give_result(4'd7, 8'd200, 3);
        check("A done", 32'(done), 1);
        check("A img_cnt", 32'(img_cnt), 1);
        check("A busy at finish", 32'(busy), 0);
        tick();
        check("A done one cycle", 32'(done), 0);
        read_entry("A tbl0", 0, 7, 200);

        // Single image, ready toggling, spurious results during streaming
        do_start(1);
        stream_img(0, N_PIX, 1'b1, 1'b1, 1'b0, hs, bad, sb);
        check("B handshakes", hs, N_PIX);
        check("B pixel errors", bad, 0);
        check("B stall stability errors", sb, 0);
        check("B img_cnt before result", 32'(img_cnt), 0);
        give_result(4'd4, 8'd44, 0);
        check("B done", 32'(done), 1);
        check("B img_cnt", 32'(img_cnt), 1);
        tick();
        read_entry("B tbl0", 0, 4, 44);

        // Three images
        do_start(3);
        stream_img(0, N_PIX, 1'b0, 1'b0, 1'b0, hs, bad, sb);
        check("C0 handshakes", hs, N_PIX);
        check("C0 pixel errors", bad, 0);
        give_result(4'd3, 8'd10, 2);
        check("C0 busy", 32'(busy), 1);
        check("C0 done", 32'(done), 0);
        check("C0 img_cnt", 32'(img_cnt), 1);
        check("C0 px_valid next image", 32'(cls_if.px_valid), 1);
        stream_img(1, N_PIX, 1'b1, 1'b0, 1'b0, hs, bad, sb);
        check("C1 handshakes", hs, N_PIX);
        check("C1 pixel errors", bad, 0);
        check("C1 stall stability errors", sb, 0);
        give_result(4'd5, 8'd20, 1);
        stream_img(2, N_PIX, 1'b0, 1'b0, 1'b0, hs, bad, sb);
        check("C2 handshakes", hs, N_PIX);
        check("C2 pixel errors", bad, 0);
        give_result(4'd9, 8'd30, 5);
        check("C done", 32'(done), 1);
        check("C img_cnt", 32'(img_cnt), 3);
        tick();
        for (int i = 0; i < 4; i++)
            read_entry($sformatf("C tbl%0d", rv[i].idx), rv[i].idx, rv[i].exp_pred, rv[i].exp_conf);

        // Watchdog expiry
        do_start(1);
        stream_img(0, N_PIX, 1'b0, 1'b0, 1'b0, hs, bad, sb);
        check("D handshakes", hs, N_PIX);
        n = 0;
        while (!done && n < TIMEOUT + 100) begin
            tick();
            n++;
        end
        check("D cycles to done", n, TIMEOUT);
        check("D timeout_err", 32'(timeout_err), 1);
        check("D img_cnt", 32'(img_cnt), 0);
        tick();
        check("D done one cycle", 32'(done), 0);
        check("D timeout_err sticky", 32'(timeout_err), 1);
        read_entry("D tbl0 unchanged", 0, 3, 10);

        // Invalid run lengths
        for (int i = 0; i < 3; i++) begin
            do_start(sv[i].num);
            check($sformatf("inv%0d done", sv[i].num), 32'(done), 32'(sv[i].exp_done));
            check($sformatf("inv%0d busy", sv[i].num), 32'(busy), 32'(sv[i].exp_busy));
            check($sformatf("inv%0d timeout_err", sv[i].num), 32'(timeout_err), 32'(sv[i].exp_terr));
            tick();
            check($sformatf("inv%0d done cleared", sv[i].num), 32'(done), 0);
            check($sformatf("inv%0d busy after", sv[i].num), 32'(busy), 0);
        end

        // Reset in the middle of streaming
        do_start(1);
        stream_img(0, 100, 1'b0, 1'b0, 1'b0, hs, bad, sb);
        check("E partial handshakes", hs, 100);
        check("E streaming", 32'(cls_if.px_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("E async px_valid", 32'(cls_if.px_valid), 0);
        check("E async busy", 32'(busy), 0);
        check("E async img_cnt", 32'(img_cnt), 0);
        read_entry("E tbl0 cleared", 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("E no pixels after reset", 32'(cls_if.px_valid), 0);
        do_start(1);
        stream_img(0, N_PIX, 1'b0, 1'b0, 1'b0, hs, bad, sb);
        check("E restart handshakes", hs, N_PIX);
        check("E restart pixel errors", bad, 0);
        give_result(4'd2, 8'd3, 0);
        check("E done", 32'(done), 1);
        check("E img_cnt", 32'(img_cnt), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
